// File: rtl/spi_pkg.sv
// Shared definitions for the multi-slave SPI master: FSM states, register map,
// control/status bit positions and the transfer-length clamp.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } spi_state_e;

    localparam logic [4:0] OFS_STATUS = 5'h00;
    localparam logic [4:0] OFS_CTRL   = 5'h04;
    localparam logic [4:0] OFS_CFG    = 5'h08;
    localparam logic [4:0] OFS_RX     = 5'h0C;
    localparam logic [4:0] OFS_TX     = 5'h10;

    localparam int STAT_READY    = 0;
    localparam int STAT_FINISHED = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_ERR      = 3;

    localparam int CTRL_ARM  = 0;
    localparam int CTRL_CPOL = 1;
    localparam int CTRL_CPHA = 2;

    localparam int CFG_DIV_LSB = 0;
    localparam int CFG_LEN_LSB = 8;
    localparam int CFG_SS_LSB  = 16;
    localparam int CFG_WID     = 20;

    // A length of 0 still moves one bit; anything past the shifter width is cut.
    function automatic logic [7:0] clamp_len(input logic [7:0] len, input int max_wid);
        if (len == 8'd0) return 8'd1;
        if (int'(len) > max_wid) return 8'(max_wid);
        return len;
    endfunction

endpackage

// File: rtl/spi_engine.sv
// SPI shift engine: sequences SS, generates SCK and shifts one transfer.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | SS released, sck follows cpol, waiting for start
//   ST_SETUP | SS asserted, SS_WAIT clocks before the first SCK edge
//   ST_SHIFT | 2*L half-periods of H clocks each, data moving
//   ST_HOLD  | final trailing-edge cycle plus SS_WAIT clocks, SS still low
//   ST_DONE  | SS released, rx valid, waiting for clear
module spi_engine
    import spi_pkg::*;
#(
    parameter int MAX_WID = 32,
    parameter int NUM_SS  = 4,
    parameter int SS_WAIT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               clear_i,
    input  logic               cpol_i,
    input  logic               cpha_i,
    input  logic [7:0]         div_i,
    input  logic [7:0]         len_i,
    input  logic [3:0]         ss_idx_i,
    input  logic [MAX_WID-1:0] tx_i,
    input  logic               miso_i,
    output spi_state_e         state_o,
    output logic [MAX_WID-1:0] rx_o,
    output logic               sck_o,
    output logic               mosi_o,
    output logic [NUM_SS-1:0]  ss_l_o
);

    spi_state_e         state_q;
    logic               cpha_q;
    logic [7:0]         div_q;
    logic [15:0]        cnt_q;
    logic [8:0]         halves_q;
    logic [MAX_WID-1:0] sr_q;
    logic [MAX_WID-1:0] rxs_q;
    logic [MAX_WID-1:0] rx_q;
    logic               sck_q;
    logic               mosi_q;
    logic [NUM_SS-1:0]  ss_q;

    logic [7:0]         len_eff;
    logic [MAX_WID-1:0] tx_al;
    logic               lead;

    // Left-align the word so the first bit out always sits in the MSB.
    always_comb begin
        len_eff = clamp_len(len_i, MAX_WID);
        tx_al   = tx_i << (8'(MAX_WID) - len_eff);
        lead    = ~halves_q[0];
    end

    // Transfer sequencer with registered pin outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cpha_q   <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
            halves_q <= '0;
            sr_q     <= '0;
            rxs_q    <= '0;
            rx_q     <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            ss_q     <= '1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sck_q <= cpol_i;
                    if (start_i) begin
                        state_q  <= ST_SETUP;
                        cnt_q    <= 16'(SS_WAIT - 1);
                        cpha_q   <= cpha_i;
                        div_q    <= div_i;
                        halves_q <= {len_eff, 1'b0};
                        ss_q     <= ~(NUM_SS'(1) << ss_idx_i);
                        rxs_q    <= '0;
                        if (cpha_i) begin
                            sr_q   <= tx_al;
                            mosi_q <= 1'b0;
                        end else begin
                            sr_q   <= tx_al << 1;
                            mosi_q <= tx_al[MAX_WID-1];
                        end
                    end
                end
                ST_SETUP: begin
                    sck_q <= cpol_i;
                    if (cnt_q == '0) begin
                        state_q <= ST_SHIFT;
                        cnt_q   <= {8'd0, div_q};
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == '0) begin
                        cnt_q    <= {8'd0, div_q};
                        sck_q    <= ~sck_q;
                        halves_q <= halves_q - 9'd1;
                        if (lead ^ cpha_q) begin
                            rxs_q <= (rxs_q << 1) | MAX_WID'(miso_i);
                        end else begin
                            mosi_q <= sr_q[MAX_WID-1];
                            sr_q   <= sr_q << 1;
                        end
                        if (halves_q == 9'd1) begin
                            state_q <= ST_HOLD;
                            cnt_q   <= 16'(SS_WAIT);
                        end
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_HOLD: begin
                    sck_q <= cpol_i;
                    if (cnt_q == '0) begin
                        state_q <= ST_DONE;
                        ss_q    <= '1;
                        rx_q    <= rxs_q;
                    end else begin
                        cnt_q <= cnt_q - 16'd1;
                    end
                end
                ST_DONE: begin
                    sck_q <= cpol_i;
                    if (clear_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign state_o = state_q;
    assign rx_o    = rx_q;
    assign sck_o   = sck_q;
    assign mosi_o  = mosi_q;
    assign ss_l_o  = ss_q;

endmodule

// File: rtl/spi_master_multi_wb.sv
// Wishbone register front end for the multi-slave SPI master.
module spi_master_multi_wb
    import spi_pkg::*;
#(
    parameter int BUS_WID = 32,
    parameter int MAX_WID = 32,
    parameter int NUM_SS  = 4,
    parameter int SS_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miso,
    output logic                 mosi,
    output logic                 sck_wire,
    output logic [NUM_SS-1:0]    ss_L,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [BUS_WID/8-1:0] wb_sel,
    input  logic [BUS_WID-1:0]   wb_addr,
    input  logic [BUS_WID-1:0]   wb_dat_w,
    output logic                 wb_ack,
    output logic [BUS_WID-1:0]   wb_dat_r
);

    logic               ack_q;
    logic [BUS_WID-1:0] dat_q;
    logic               arm_q, arm_d;
    logic               cpol_q, cpol_d;
    logic               cpha_q, cpha_d;
    logic               err_q, err_d;
    logic [CFG_WID-1:0] cfg_q;
    logic [BUS_WID-1:0] tx_q;

    spi_state_e         state;
    logic [MAX_WID-1:0] rx;
    logic               req, wr, busy, ss_ok, eng_start, eng_clear;
    logic [4:0]         ofs;
    logic [3:0]         status;
    logic [BUS_WID-1:0] rd_d;
    logic               unused_bits;

    assign unused_bits = ^{wb_sel, wb_addr[BUS_WID-1:5]};

    assign wb_ack   = ack_q & wb_cyc;
    assign wb_dat_r = dat_q;
    assign req      = wb_cyc & wb_stb & ~wb_ack;
    assign wr       = req & wb_we;
    assign ofs      = wb_addr[4:0];
    assign busy     = (state == ST_SETUP) || (state == ST_SHIFT) || (state == ST_HOLD);
    assign ss_ok    = int'(cfg_q[CFG_SS_LSB +: 4]) < NUM_SS;

    // CTRL update and start/clear decisions; arm only starts from IDLE.
    always_comb begin
        arm_d     = arm_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        err_d     = err_q;
        eng_start = 1'b0;
        eng_clear = 1'b0;
        if (wr && ofs == OFS_CTRL) begin
            if (!busy) begin
                cpol_d = wb_dat_w[CTRL_CPOL];
                cpha_d = wb_dat_w[CTRL_CPHA];
            end
            if (!wb_dat_w[CTRL_ARM]) begin
                err_d = 1'b0;
                if (!busy) begin
                    arm_d     = 1'b0;
                    eng_clear = (state == ST_DONE);
                end
            end else if (state == ST_IDLE) begin
                if (ss_ok) begin
                    arm_d     = 1'b1;
                    eng_start = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // Read mux; unmapped offsets return zero.
    always_comb begin
        status                = '0;
        status[STAT_READY]    = (state == ST_IDLE);
        status[STAT_FINISHED] = (state == ST_DONE);
        status[STAT_BUSY]     = busy;
        status[STAT_ERR]      = err_q;
        rd_d                  = '0;
        case (ofs)
            OFS_STATUS: rd_d = BUS_WID'(status);
            OFS_CTRL:   rd_d = BUS_WID'({cpha_q, cpol_q, arm_q});
            OFS_CFG:    rd_d = BUS_WID'(cfg_q);
            OFS_RX:     rd_d = BUS_WID'(rx);
            OFS_TX:     rd_d = tx_q;
            default:    rd_d = '0;
        endcase
    end

    // Bus handshake and register storage; CFG/TX are frozen while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            arm_q  <= 1'b0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            err_q  <= 1'b0;
            cfg_q  <= '0;
            tx_q   <= '0;
        end else begin
            ack_q  <= req;
            if (req) dat_q <= rd_d;
            arm_q  <= arm_d;
            cpol_q <= cpol_d;
            cpha_q <= cpha_d;
            err_q  <= err_d;
            if (wr && !busy) begin
                if (ofs == OFS_CFG) cfg_q <= wb_dat_w[CFG_WID-1:0];
                if (ofs == OFS_TX)  tx_q  <= wb_dat_w;
            end
        end
    end

    spi_engine #(
        .MAX_WID (MAX_WID),
        .NUM_SS  (NUM_SS),
        .SS_WAIT (SS_WAIT)
    ) u_engine (
        .clk      (clk),
        .rst      (rst),
        .start_i  (eng_start),
        .clear_i  (eng_clear),
        .cpol_i   (cpol_d),
        .cpha_i   (cpha_d),
        .div_i    (cfg_q[CFG_DIV_LSB +: 8]),
        .len_i    (cfg_q[CFG_LEN_LSB +: 8]),
        .ss_idx_i (cfg_q[CFG_SS_LSB +: 4]),
        .tx_i     (tx_q[MAX_WID-1:0]),
        .miso_i   (miso),
        .state_o  (state),
        .rx_o     (rx),
        .sck_o    (sck_wire),
        .mosi_o   (mosi),
        .ss_l_o   (ss_L)
    );

endmodule

// File: tb/tb_spi_master_multi_wb.sv
// Self-checking bench for spi_master_multi_wb with an RX scoreboard.
module tb_spi_master_multi_wb;

    localparam logic [31:0] A_STATUS = 32'h00;
    localparam logic [31:0] A_CTRL   = 32'h04;
    localparam logic [31:0] A_CFG    = 32'h08;
    localparam logic [31:0] A_RX     = 32'h0C;
    localparam logic [31:0] A_TX     = 32'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [3:0]  wb_sel = 4'hF;
    logic [31:0] wb_addr = '0, wb_dat_w = '0;
    wire         wb_ack;
    wire  [31:0] wb_dat_r;
    wire         mosi, sck_wire;
    wire  [3:0]  ss_L;
    logic        loop_en = 1'b0, miso_tie = 1'b0;
    wire         miso = loop_en ? mosi : miso_tie;

    int n_vec = 0, n_err = 0;
    int cyc_cnt = 0, n_rise = 0, n_fall = 0;
    logic [31:0] sb_q[$];

    spi_master_multi_wb dut (
        .clk(clk), .rst(rst), .miso(miso), .mosi(mosi), .sck_wire(sck_wire),
        .ss_L(ss_L), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we),
        .wb_sel(wb_sel), .wb_addr(wb_addr), .wb_dat_w(wb_dat_w),
        .wb_ack(wb_ack), .wb_dat_r(wb_dat_r)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
    always @(posedge sck_wire) if (ss_L != 4'hF) n_rise++;
    always @(negedge sck_wire) if (ss_L != 4'hF) n_fall++;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the ack edge (cycle T+1).
    task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rdata);
        int n = 0;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_addr = addr; wb_dat_w = data;
        do begin
            @(posedge clk); #1; n++;
        end while (wb_ack !== 1'b1 && n < 8);
        chk_val("ack", 32'(wb_ack), 32'd1);
        rdata = wb_dat_r;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] d;
        wb_xfer(1'b1, addr, data, d);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, addr, 32'h0, d);
        chk_val(tag, d, exp);
    endtask

    task automatic wait_done(output int t_done, output int t_first);
        int n = 0;
        logic s0 = sck_wire;
        t_first = -1;
        while (ss_L !== 4'hF && n < 3000) begin
            @(posedge clk); #1; n++;
            if (t_first < 0 && sck_wire !== s0) t_first = cyc_cnt;
        end
        t_done = cyc_cnt;
        chk_val("done_wait", 32'(ss_L), 32'hF);
    endtask

    task automatic sb_pop_rx(input string tag);
        logic [31:0] d;
        wb_xfer(1'b0, A_RX, 32'h0, d);
        if (sb_q.size() == 0) chk_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd1);
        else chk_val(tag, d, sb_q.pop_front());
    endtask

    function automatic logic [31:0] exp_rx(input logic [31:0] tx, input int len, input int mode);
        int L;
        logic [31:0] mask;
        L = (len == 0) ? 1 : ((len > 32) ? 32 : len);
        mask = (L == 32) ? 32'hFFFF_FFFF : ((32'd1 << L) - 32'd1);
        if (mode == 0) return tx & mask;
        if (mode == 1) return mask;
        return 32'h0;
    endfunction

    initial begin
        int t1, td, tf, base;

        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_ss", 32'(ss_L), 32'hF);
        chk_val("rst_sck", 32'(sck_wire), 32'd0);
        chk_val("rst_mosi", 32'(mosi), 32'd0);
        chk_val("rst_ack", 32'(wb_ack), 32'd0);
        chk_val("rst_dat", wb_dat_r, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ack is a single-cycle pulse even with the strobe held
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = A_STATUS;
        @(posedge clk); #1;
        chk_val("ack_t1", 32'(wb_ack), 32'd1);
        chk_val("status_rst", wb_dat_r, 32'h1);
        @(posedge clk); #1;
        chk_val("ack_t2", 32'(wb_ack), 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        rd_chk("ctrl_rst", A_CTRL, 32'h0);
        rd_chk("cfg_rst", A_CFG, 32'h0);
        rd_chk("tx_rst", A_TX, 32'h0);
        wb_wr(32'h14, 32'hFFFF_FFFF);
        rd_chk("unmapped", 32'h14, 32'h0);

        // mode 0 loopback, div=1, len=8, ss_idx=2
        loop_en = 1'b1;
        wb_wr(A_CFG, 32'h0002_0801);
        wb_wr(A_TX, 32'hA5);
        wb_wr(A_CTRL, 32'h1);
        t1 = cyc_cnt;
        sb_q.push_back(exp_rx(32'hA5, 8, 0));
        chk_val("m0_ss", 32'(ss_L), 32'hB);
        wait_done(td, tf);
        chk_val("m0_first_edge", 32'(tf - t1), 32'd3);
        chk_val("m0_finish", 32'(td - t1), 32'd35);
        rd_chk("m0_status_fin", A_STATUS, 32'h2);
        sb_pop_rx("m0_rx");
        wb_wr(A_CTRL, 32'h0);
        rd_chk("m0_status_idle", A_STATUS, 32'h1);

        // cpol change in idle, then mode 3 with len=0 and miso tied high
        wb_wr(A_CTRL, 32'h6);
        chk_val("cpol_idle", 32'(sck_wire), 32'd1);
        loop_en = 1'b0; miso_tie = 1'b1;
        wb_wr(A_CFG, 32'h0);
        wb_wr(A_TX, 32'h1);
        base = n_fall;
        wb_wr(A_CTRL, 32'h7);
        sb_q.push_back(exp_rx(32'h1, 0, 1));
        wait_done(td, tf);
        chk_val("m3_pulses", 32'(n_fall - base), 32'd1);
        chk_val("m3_sck_idle", 32'(sck_wire), 32'd1);
        sb_pop_rx("m3_rx");
        wb_wr(A_CTRL, 32'h0);
        chk_val("cpol_back", 32'(sck_wire), 32'd0);

        // len=40 clamps to 32; writes while busy are discarded
        loop_en = 1'b1; miso_tie = 1'b0;
        wb_wr(A_CFG, 32'h0001_2800);
        wb_wr(A_TX, 32'hDEAD_BEEF);
        base = n_rise;
        wb_wr(A_CTRL, 32'h1);
        sb_q.push_back(exp_rx(32'hDEAD_BEEF, 40, 0));
        chk_val("w32_ss", 32'(ss_L), 32'hD);
        wb_wr(A_TX, 32'h1234);
        wb_wr(A_CFG, 32'h0000_FFFF);
        rd_chk("w32_status_busy", A_STATUS, 32'h4);
        wait_done(td, tf);
        chk_val("w32_sck_cycles", 32'(n_rise - base), 32'd32);
        sb_pop_rx("w32_rx");
        rd_chk("w32_tx_kept", A_TX, 32'hDEAD_BEEF);
        rd_chk("w32_cfg_kept", A_CFG, 32'h0001_2800);
        wb_wr(A_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        chk_val("rearm_ss", 32'(ss_L), 32'hF);
        rd_chk("rearm_status", A_STATUS, 32'h2);
        rd_chk("rearm_ctrl", A_CTRL, 32'h1);
        wb_wr(A_CTRL, 32'h0);
        rd_chk("rearm_idle", A_STATUS, 32'h1);

        // out-of-range slave select
        wb_wr(A_CFG, 32'h0005_0801);
        wb_wr(A_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        chk_val("badss_ss", 32'(ss_L), 32'hF);
        rd_chk("badss_status", A_STATUS, 32'h9);
        rd_chk("badss_ctrl", A_CTRL, 32'h0);
        wb_wr(A_CTRL, 32'h0);
        rd_chk("badss_errclr", A_STATUS, 32'h1);

        // async reset during the third bit
        wb_wr(A_CFG, 32'h0000_0801);
        wb_wr(A_TX, 32'hFF);
        base = n_rise;
        wb_wr(A_CTRL, 32'h1);
        for (int i = 0; i < 200 && (n_rise - base) < 3; i++) begin
            @(posedge clk); #1;
        end
        chk_val("rst_mid_sck_pre", 32'(sck_wire), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk_val("rst_mid_ss", 32'(ss_L), 32'hF);
        chk_val("rst_mid_sck", 32'(sck_wire), 32'd0);
        chk_val("rst_mid_mosi", 32'(mosi), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        rd_chk("rst_mid_status", A_STATUS, 32'h1);
        rd_chk("rst_mid_cfg", A_CFG, 32'h0);
        rd_chk("rst_mid_tx", A_TX, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
